min_distance_tracker: RTL and testbench

//  Sequential minimum-finder for the less-distance datapath: accepts a stream of unsigned distances and

---
 rtl/min_distance_tracker_pkg.sv | 18 +
 rtl/min_distance_tracker_if.sv | 26 ++
 rtl/lt_eq_digit_slice.sv | 15 +
 rtl/min_distance_tracker.sv | 122 ++++++++++++
 tb/tb_min_distance_tracker.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/min_distance_tracker_pkg.sv
// rtl/min_distance_tracker_pkg.sv - shared types and helpers for the min-distance tracker
// Holds FSM state encodings, the compare digit width and the digit-count helper.
package less_distance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DIGIT_W = 2;

    function automatic int digit_count(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/min_distance_tracker_if.sv
// rtl/min_distance_tracker_if.sv - sample stream and result bundle for the min-distance tracker
// master = producer/consumer side, slave = tracker side.
interface min_distance_tracker_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dist;
    logic             in_last;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_min;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output start, in_valid, in_dist, in_last,
        input  in_ready, busy, out_valid, out_min, out_idx
    );

    modport slave (
        input  start, in_valid, in_dist, in_last,
        output in_ready, busy, out_valid, out_min, out_idx
    );
endinterface

// File: rtl/lt_eq_digit_slice.sv
// rtl/lt_eq_digit_slice.sv - one 2-bit cascade slice of an MSB-first a < b magnitude compare
// eq/lt from the more significant digits flow in; updated eq/lt flow out.
module lt_eq_digit_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       eq_in,
    input  logic       lt_in,
    output logic       eq_o,
    output logic       lt_o
);
    assign lt_o = (~a[1] & b[1] & eq_in)
                | (~a[0] & b[0] & (a[1] ~^ b[1]) & eq_in)
                | lt_in;
    assign eq_o = eq_in & (a == b);
endmodule

// File: rtl/min_distance_tracker.sv
// rtl/min_distance_tracker.sv - streaming minimum finder using a digit-serial magnitude compare
// Build option: MIN_DIST_TIE_LATEST_EN makes the latest of equal minima win.
module min_distance_tracker
    import less_distance_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input logic                   clk,
    input logic                   rst,
    min_distance_tracker_if.slave bus
);
    localparam int D     = digit_count(WIDTH);
    localparam int DIG_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [DIG_W-1:0] DIG_TOP = DIG_W'(D - 1);

    state_t             state;
    logic [WIDTH-1:0]   cand;
    logic [WIDTH-1:0]   min_r;
    logic [IDX_W-1:0]   cand_idx;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   count;
    logic               cand_last;
    logic               first_flag;
    logic               eq_r;
    logic               lt_r;
    logic [DIG_W-1:0]   dig;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic               eq_o;
    logic               lt_o;
    logic               take;
    logic               accept;

    // Single shared slice; the digit counter selects which 2 bits it sees.
    assign a_dig = cand[dig*DIGIT_W +: DIGIT_W];
    assign b_dig = min_r[dig*DIGIT_W +: DIGIT_W];

    lt_eq_digit_slice u_slice (
        .a     (a_dig),
        .b     (b_dig),
        .eq_in (eq_r),
        .lt_in (lt_r),
        .eq_o  (eq_o),
        .lt_o  (lt_o)
    );

`ifdef MIN_DIST_TIE_LATEST_EN
    assign take = lt_o | eq_o;
`else
    assign take = lt_o;
`endif

    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.in_ready  = (state == ST_WAIT);
    assign bus.busy      = (state == ST_WAIT) || (state == ST_CMP);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_min   = min_r;
    assign bus.out_idx   = idx_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cand       <= '0;
            min_r      <= '0;
            cand_idx   <= '0;
            idx_r      <= '0;
            count      <= '0;
            cand_last  <= 1'b0;
            first_flag <= 1'b0;
            eq_r       <= 1'b1;
            lt_r       <= 1'b0;
            dig        <= '0;
        end else if (bus.start) begin
            // Also aborts an in-flight compare; the candidate is simply dropped.
            state      <= ST_WAIT;
            min_r      <= '0;
            idx_r      <= '0;
            count      <= '0;
            first_flag <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: ;
                ST_WAIT: begin
                    if (accept) begin
                        if (first_flag) begin
                            min_r      <= bus.in_dist;
                            idx_r      <= '0;
                            count      <= IDX_W'(1);
                            first_flag <= 1'b0;
                            state      <= bus.in_last ? ST_DONE : ST_WAIT;
                        end else begin
                            cand      <= bus.in_dist;
                            cand_idx  <= count;
                            cand_last <= bus.in_last;
                            count     <= count + 1'b1;
                            eq_r      <= 1'b1;
                            lt_r      <= 1'b0;
                            dig       <= DIG_TOP;
                            state     <= ST_CMP;
                        end
                    end
                end
                ST_CMP: begin
                    if (dig != '0) begin
                        eq_r <= eq_o;
                        lt_r <= lt_o;
                        dig  <= dig - 1'b1;
                    end else begin
                        if (take) begin
                            min_r <= cand;
                            idx_r <= cand_idx;
                        end
                        state <= cand_last ? ST_DONE : ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_min_distance_tracker.sv
// tb/tb_min_distance_tracker.sv - directed, table-driven bench for min_distance_tracker
module tb_min_distance_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    min_distance_tracker_if #(.WIDTH(8), .IDX_W(4)) bus ();

    min_distance_tracker #(.WIDTH(8), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int              n;
        logic [2:0][7:0] d;
        logic [7:0]      emin;
        logic [3:0]      eidx;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input bit first);
        int w;
        int lat;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        check("ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_dist  = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        lat = 0;
        while (!bus.in_ready && !bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("busy_cycles", 32'(lat), first ? 32'd0 : 32'd4);
    endtask

    task automatic check_result(input string tag, input logic [7:0] emin, input logic [3:0] eidx);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_min"},   32'(bus.out_min),   32'(emin));
        check({tag, "_idx"},   32'(bus.out_idx),   32'(eidx));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_dist  = '0;
        bus.in_last  = 1'b0;

        vecs[0] = '{3, {8'h70, 8'h30, 8'h50}, 8'h30, 4'd1};
`ifdef MIN_DIST_TIE_LATEST_EN
        vecs[1] = '{2, {8'h00, 8'h22, 8'h22}, 8'h22, 4'd1};
`else
        vecs[1] = '{2, {8'h00, 8'h22, 8'h22}, 8'h22, 4'd0};
`endif
        vecs[2] = '{2, {8'h00, 8'h40, 8'h41}, 8'h40, 4'd1};
        vecs[3] = '{2, {8'h00, 8'h41, 8'h40}, 8'h40, 4'd0};
        vecs[4] = '{1, {8'h00, 8'h00, 8'hFF}, 8'hFF, 4'd0};
        vecs[5] = '{3, {8'h05, 8'h60, 8'h70}, 8'h05, 4'd2};
        vecs[6] = '{3, {8'hC2, 8'hC1, 8'hC3}, 8'hC1, 4'd1};
        vecs[7] = '{3, {8'h7F, 8'h81, 8'h80}, 8'h7F, 4'd2};

        // Reset held two cycles, then confirm IDLE ignores in_valid.
        tick();
        tick();
        check("rst_ready", 32'(bus.in_ready),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_min",   32'(bus.out_min),   32'd0);
        check("rst_idx",   32'(bus.out_idx),   32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        check("idle_ready", 32'(bus.in_ready), 32'd0);
        check("idle_busy",  32'(bus.busy),     32'd0);
        bus.in_valid = 1'b0;

        for (int v = 0; v < 8; v++) begin
            pulse_start();
            check("start_valid", 32'(bus.out_valid), 32'd0);
            check("start_ready", 32'(bus.in_ready),  32'd1);
            for (int s = 0; s < vecs[v].n; s++)
                send(vecs[v].d[s], s == vecs[v].n - 1, s == 0);
            check_result($sformatf("vec%0d", v), vecs[v].emin, vecs[v].eidx);
            tick();
            check($sformatf("vec%0d_hold", v), 32'(bus.out_min), 32'(vecs[v].emin));
        end

        // Abort a compare with start in its second CMP cycle.
        pulse_start();
        send(8'h10, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_dist  = 8'h05;
        tick();
        bus.in_valid = 1'b0;
        check("abort_cmp1_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("abort_cmp2_busy", 32'(bus.busy), 32'd1);
        pulse_start();
        check("abort_ready", 32'(bus.in_ready),  32'd1);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        send(8'h09, 1'b1, 1'b1);
        check_result("abort", 8'h09, 4'd0);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_over_start_ready", 32'(bus.in_ready),  32'd0);
        check("rst_over_start_valid", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
